// File: rtl/trig_pkg.sv
// Shared constants, FSM state type and angle helper for the trig scheduler.
package trig_pkg;

  localparam int unsigned ANGLE_W = 32;
  localparam int unsigned LUT_AW  = 12;
  localparam int unsigned GRAD_W  = 32;
  localparam int unsigned OUT_W   = 64;

  // Quarter of a full turn; sine is served as cos(angle - QUARTER_TURN).
  localparam logic [ANGLE_W-1:0] QUARTER_TURN = ANGLE_W'(1) << (ANGLE_W - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LUT,
    ST_MAC,
    ST_RESP
  } state_t;

  // Effective cosine angle for a request; subtraction wraps modulo one turn.
  function automatic logic [ANGLE_W-1:0] eff_angle(input logic [ANGLE_W-1:0] angle,
                                                   input logic               is_sin);
    return is_sin ? (angle - QUARTER_TURN) : angle;
  endfunction

endpackage

// File: rtl/trig_rr_arbiter.sv
// Round-robin arbiter: combinational grant searched from the pointer, pointer register.
module trig_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr;
  int unsigned   j;

  // First requesting port at or after the pointer, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && req[IW'(j)]) begin
        any       = 1'b1;
        grant_idx = IW'(j);
      end
    end
    if (any) grant = N'(1) << grant_idx;
  end

  // Pointer moves just past the port that won.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/trig_sched.sv
// Time-shares one piecewise-linear cosine datapath between N_REQ requesters.
module trig_sched
  import trig_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*ANGLE_W-1:0] req_angle,
  input  logic [N_REQ-1:0]         req_sin,
  output logic [LUT_AW-1:0]        lut_addr,
  input  logic [GRAD_W-1:0]        lut_grad,
  input  logic [OUT_W-1:0]         lut_icpt,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [OUT_W-1:0]         resp_data
);

  localparam int unsigned IDW = $clog2(N_REQ);

  state_t             state;
  logic [ANGLE_W-1:0] eff;
  logic [IDW-1:0]     id_q;

  logic [N_REQ-1:0]   grant;
  logic [IDW-1:0]     grant_idx;
  logic               any;

  logic [ANGLE_W-1:0] sel_angle;
  logic               sel_sin;
  logic [ANGLE_W-1:0] new_eff;
  logic [OUT_W-1:0]   grad_ext;
  logic [OUT_W-1:0]   ang_ext;
  logic [OUT_W-1:0]   mac;

  trig_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (state == ST_IDLE),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Handshake only while idle, so the grant pulses for exactly the accepting cycle.
  assign req_ready = (state == ST_IDLE) ? grant : '0;

  // Select the granted port's angle and sine flag.
  always_comb begin
    sel_angle = '0;
    sel_sin   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
        sel_sin   = req_sin[i];
      end
    end
  end

  assign new_eff = eff_angle(sel_angle, sel_sin);

  // Multiply-add; the low OUT_W bits of the product are all the truncated sum needs.
  assign grad_ext = {{(OUT_W - GRAD_W){lut_grad[GRAD_W-1]}}, lut_grad};
  assign ang_ext  = {{(OUT_W - ANGLE_W){1'b0}}, eff};
  assign mac      = lut_icpt + grad_ext * ang_ext;

  // Request -> LUT read -> multiply-add -> response sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      eff        <= '0;
      id_q       <= '0;
      lut_addr   <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            eff      <= new_eff;
            id_q     <= grant_idx;
            lut_addr <= new_eff[ANGLE_W-1 -: LUT_AW];
            state    <= ST_LUT;
          end
        end
        ST_LUT: begin
          state <= ST_MAC;
        end
        ST_MAC: begin
          resp_data  <= mac;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
